// File: rtl/mbu_ctxsw.sv
// mbu_ctxsw -- register-bank context switch sequencer.
//
// Copies MB0..MB7 between an external register file and an internal
// eight-entry shadow store. While idle the control unit talks to the register
// file directly; once a request is accepted the sequencer takes over the
// register-file port and holds nwait low until it is finished.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   nreset     in   synchronous active-low reset
//   nsave      in   active-low request: register file -> shadow
//   nrestore   in   active-low request: shadow -> register file
//   cpu_sel    in   [2:0] control-unit register select
//   cpu_nwe    in   control-unit write strobe, active-low
//   cpu_noe    in   control-unit read enable, active-low
//   rf_din     in   [7:0] data read from the register file
//   rf_sel     out  [2:0] register-file address
//   rf_nwe     out  register-file write strobe, active-low
//   rf_noe     out  register-file output enable, active-low
//   rf_dout    out  [7:0] write data, 8'h00 whenever rf_nwe is high
//   nwait      out  active-low: sequencer owns the register file
//   ndone      out  active-low one-cycle completion pulse
//   dbg_state  out  [2:0] current FSM state (IDLE=0 RD=1 WR=2 GAP=3 DONE=4)
//
// Build option
//   MBU_CTXSW_SWAP_EN  when defined, simultaneous save+restore requests run an
//                      in-place swap (RD, WR, GAP per register) using a temp
//                      register. When undefined, temp is absent and a
//                      simultaneous request performs a plain save.
//
// Handshake: nsave/nrestore are level requests sampled only in IDLE. A request
// still low on the IDLE cycle following ndone is accepted again, so requesters
// must release their request when they see ndone low.

module mbu_ctxsw (
  input  logic       clk,
  input  logic       nreset,
  input  logic       nsave,
  input  logic       nrestore,
  input  logic [2:0] cpu_sel,
  input  logic       cpu_nwe,
  input  logic       cpu_noe,
  input  logic [7:0] rf_din,
  output logic [2:0] rf_sel,
  output logic       rf_nwe,
  output logic       rf_noe,
  output logic [7:0] rf_dout,
  output logic       nwait,
  output logic       ndone,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_SAVE    = 2'd0,
    OP_RESTORE = 2'd1,
    OP_SWAP    = 2'd2
  } op_t;

  state_t     state, state_nx;
  op_t        op, op_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] shadow [8];
  logic       sh_we;
  logic [7:0] sh_wdata;
`ifdef MBU_CTXSW_SWAP_EN
  logic [7:0] temp;
  logic       temp_we;
`endif

  // Next-state logic
  always_comb begin
    state_nx = state;
    op_nx    = op;
    idx_nx   = idx;
    sh_we    = 1'b0;
    sh_wdata = rf_din;
`ifdef MBU_CTXSW_SWAP_EN
    temp_we  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!nsave || !nrestore) begin
          idx_nx = 3'd0;
          if (!nsave && !nrestore) begin
`ifdef MBU_CTXSW_SWAP_EN
            op_nx    = OP_SWAP;
`else
            // Without swap support the restore half is dropped.
            op_nx    = OP_SAVE;
`endif
            state_nx = RD;
          end else if (!nsave) begin
            op_nx    = OP_SAVE;
            state_nx = RD;
          end else begin
            op_nx    = OP_RESTORE;
            state_nx = WR;
          end
        end
      end
      RD: begin
`ifdef MBU_CTXSW_SWAP_EN
        if (op == OP_SWAP) begin
          // Hold the register-file value until shadow[idx] has been written out.
          temp_we  = 1'b1;
          state_nx = WR;
        end else
`endif
        begin
          sh_we    = 1'b1;
          sh_wdata = rf_din;
          if (idx == 3'd7) state_nx = DONE;
          else             idx_nx   = idx + 3'd1;
        end
      end
      WR: begin
`ifdef MBU_CTXSW_SWAP_EN
        if (op == OP_SWAP) begin
          // shadow[idx] is being driven out this cycle; replace it at the edge.
          sh_we    = 1'b1;
          sh_wdata = temp;
        end
`endif
        state_nx = GAP;
      end
      GAP: begin
        // Recovery cycle keeps rf_nwe from being low on adjacent cycles.
        if (idx == 3'd7) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + 3'd1;
`ifdef MBU_CTXSW_SWAP_EN
          state_nx = (op == OP_SWAP) ? RD : WR;
`else
          state_nx = WR;
`endif
        end
      end
      DONE: begin
        // idx stays at 7 through DONE and only wraps here.
        idx_nx   = 3'd0;
        state_nx = IDLE;
      end
      default: begin
        idx_nx   = 3'd0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, index and shadow store
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      op    <= OP_SAVE;
      idx   <= 3'd0;
      for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
`ifdef MBU_CTXSW_SWAP_EN
      temp  <= 8'h00;
`endif
    end else begin
      state <= state_nx;
      op    <= op_nx;
      idx   <= idx_nx;
      if (sh_we) shadow[idx] <= sh_wdata;
`ifdef MBU_CTXSW_SWAP_EN
      if (temp_we) temp <= rf_din;
`endif
    end
  end

  // Register-file port and status outputs
  always_comb begin
    rf_sel  = cpu_sel;
    rf_nwe  = 1'b1;
    rf_noe  = 1'b1;
    rf_dout = 8'h00;
    nwait   = 1'b1;
    ndone   = 1'b1;
    if (nreset) begin
      case (state)
        IDLE: begin
          rf_sel = cpu_sel;
          rf_nwe = cpu_nwe;
          // A write strobe wins over a simultaneous read so the two are never
          // low together on the register-file port.
          rf_noe = cpu_noe | ~cpu_nwe;
        end
        RD: begin
          nwait  = 1'b0;
          rf_sel = idx;
          rf_noe = 1'b0;
        end
        WR: begin
          nwait   = 1'b0;
          rf_sel  = idx;
          rf_nwe  = 1'b0;
          rf_dout = shadow[idx];
        end
        GAP: begin
          nwait  = 1'b0;
          rf_sel = idx;
        end
        DONE: begin
          nwait  = 1'b0;
          ndone  = 1'b0;
          rf_sel = idx;
        end
        default: begin
          nwait = 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
